// File: rtl/cpu_exec_pkg.sv
// cpu_exec_pkg: shared types and constants for the toy-CPU execute stage.
//   opcode_e   - 4-bit instruction opcodes (OP_ADD .. OP_LDI)
//   alu_ctl_t  - ALU control word as produced by the control ROM
//   ctrl_t     - memory / write-back source controls
//   ALU_*      - ALU function-select encodings
//   MEM_WORDS_DEF - default data memory depth in 16-bit words
package cpu_exec_pkg;

  localparam int MEM_WORDS_DEF = 128;
  localparam int DW_DEF        = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHR = 4'h6,
    OP_MOV = 4'h7,
    OP_ST  = 4'hD,
    OP_LD  = 4'hE,
    OP_LDI = 4'hF
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Bit order matches alu_ctl[7:0]: [7] inv_a ... [0] zero_a.
  typedef struct packed {
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic [1:0] func;
    logic       inv_res;
    logic       shr;
    logic       zero_a;
  } alu_ctl_t;

  typedef struct packed {
    logic mem_we;
    logic mem_re;
    logic ldi;
  } ctrl_t;

  // Opcodes 0x8..0xC carry no operation.
  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hC);
  endfunction

endpackage

// File: rtl/cpu_exec_unit_alu.sv
// exec_alu: purely combinational 8-bit ALU.
//   i_a, i_b   - operands (A = rs1 side, B = rs2 side)
//   i_ctl      - alu_ctl_t control word
//   o_result   - truncated result after optional invert / shift
//   o_carry    - bit DW of the sum for ALU_ADD, 0 for logic functions
//   o_zero     - result == 0
//   o_negative - result MSB
module exec_alu
  import cpu_exec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  alu_ctl_t      i_ctl,
  output logic [DW-1:0] o_result,
  output logic          o_carry,
  output logic          o_zero,
  output logic          o_negative
);

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_raw;
  logic [DW-1:0] w_res;
  logic          w_carry;

  always_comb begin
    // Forcing A to zero happens before the optional inversion.
    w_a = i_ctl.zero_a ? '0 : i_a;
    if (i_ctl.inv_a) w_a = ~w_a;
    w_b = i_ctl.inv_b ? ~i_b : i_b;

    w_sum = {1'b0, w_a} + {1'b0, w_b} + {{DW{1'b0}}, i_ctl.cin};

    w_raw   = '0;
    w_carry = 1'b0;
    case (i_ctl.func)
      ALU_ADD: begin
        w_raw   = w_sum[DW-1:0];
        w_carry = w_sum[DW];
      end
      ALU_AND: w_raw = w_a & w_b;
      ALU_OR:  w_raw = w_a | w_b;
      default: w_raw = w_a ^ w_b;
    endcase

    w_res = i_ctl.inv_res ? ~w_raw : w_raw;
    if (i_ctl.shr) w_res = {1'b0, w_res[DW-1:1]};
  end

  assign o_result   = w_res;
  assign o_carry    = w_carry;
  assign o_zero     = (w_res == '0);
  assign o_negative = w_res[DW-1];

endmodule

// File: rtl/cpu_exec_unit.sv
// cpu_exec_unit: single-cycle execute/memory stage of the 16-bit toy CPU.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   inst                - {opcode, rd, rs1, rs2}; imm = inst[7:0]
//   rs1_data, rs2_data  - register-file read data
//   rs1_addr, rs2_addr  - register-file read addresses (from inst)
//   rd_we, rd_addr, rd_wdata - register-file write port
//   status              - registered {carry, zero, negative}
//   illegal_op          - sticky reserved-opcode flag
// Optional feature macro: EXEC_ILLEGAL_OP_EN builds the sticky illegal_op
// detector; without it illegal_op is tied low.
module cpu_exec_unit
  import cpu_exec_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   inst,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  output logic [3:0]    rs1_addr,
  output logic [3:0]    rs2_addr,
  output logic          rd_we,
  output logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_wdata,
  output logic [2:0]    status,
  output logic          illegal_op
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [3:0]      w_op;
  alu_ctl_t        w_alu_ctl;
  ctrl_t           w_ctrl;
  logic            w_zero_b;
  logic            w_alu_op;
  logic [DW-1:0]   w_b_op;
  logic [DW-1:0]   w_alu_res;
  logic            w_carry;
  logic            w_zero;
  logic            w_neg;
  logic [6:0]      w_widx_full;
  logic [AW-1:0]   w_widx;
  logic [2*DW-1:0] w_rword;
  logic [DW-1:0]   w_rbyte;

  logic [2*DW-1:0] r_mem [MEM_WORDS];
  logic [2:0]      r_status;

  assign w_op     = inst[15:12];
  assign rs1_addr = inst[7:4];
  assign rs2_addr = inst[3:0];
  assign rd_addr  = inst[11:8];
  assign w_alu_op = ~inst[15];

  // Control ROM. Single-operand ops (NOT/SHR/MOV) also zero the B operand
  // so rs2_data cannot leak into the OR.
  always_comb begin
    w_alu_ctl = '0;
    w_ctrl    = '0;
    w_zero_b  = 1'b0;
    case (w_op)
      OP_ADD: w_alu_ctl.func = ALU_ADD;
      OP_SUB: begin
        w_alu_ctl.func  = ALU_ADD;
        w_alu_ctl.inv_b = 1'b1;
        w_alu_ctl.cin   = 1'b1;
      end
      OP_AND: w_alu_ctl.func = ALU_AND;
      OP_OR:  w_alu_ctl.func = ALU_OR;
      OP_XOR: w_alu_ctl.func = ALU_XOR;
      OP_NOT: begin
        w_alu_ctl.func  = ALU_OR;
        w_alu_ctl.inv_a = 1'b1;
        w_zero_b        = 1'b1;
      end
      OP_SHR: begin
        w_alu_ctl.func = ALU_OR;
        w_alu_ctl.shr  = 1'b1;
        w_zero_b       = 1'b1;
      end
      OP_MOV: begin
        w_alu_ctl.func = ALU_OR;
        w_zero_b       = 1'b1;
      end
      OP_ST:  w_ctrl.mem_we = 1'b1;
      OP_LD:  w_ctrl.mem_re = 1'b1;
      OP_LDI: w_ctrl.ldi    = 1'b1;
      default: begin
        w_alu_ctl = '0;
        w_ctrl    = '0;
      end
    endcase
  end

  assign w_b_op = w_zero_b ? '0 : rs2_data;

  exec_alu #(
    .DW(DW)
  ) u_alu (
    .i_a        (rs1_data),
    .i_b        (w_b_op),
    .i_ctl      (w_alu_ctl),
    .o_result   (w_alu_res),
    .o_carry    (w_carry),
    .o_zero     (w_zero),
    .o_negative (w_neg)
  );

  // Byte address rs1_data: word = addr[7:1] modulo depth, lane = addr[0].
  assign w_widx_full = rs1_data[7:1];
  assign w_widx      = w_widx_full[AW-1:0];
  assign w_rword     = r_mem[w_widx];
  assign w_rbyte     = rs1_data[0] ? w_rword[2*DW-1:DW] : w_rword[DW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_ctrl.mem_we) begin
      if (rs1_data[0]) r_mem[w_widx][2*DW-1:DW] <= rs2_data;
      else             r_mem[w_widx][DW-1:0]    <= rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_status <= 3'b000;
    else if (w_alu_op) r_status <= {w_carry, w_zero, w_neg};
  end

  assign status = r_status;

  always_comb begin
    if (w_ctrl.ldi)         rd_wdata = inst[7:0];
    else if (w_ctrl.mem_re) rd_wdata = w_rbyte;
    else                    rd_wdata = w_alu_res;
  end

  assign rd_we = rst_n & (w_alu_op | w_ctrl.mem_re | w_ctrl.ldi);

`ifdef EXEC_ILLEGAL_OP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n)                r_illegal <= 1'b0;
    else if (is_reserved(w_op)) r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_exec_unit.sv
module tb_cpu_exec_unit;

  localparam int MW = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst;
  logic [7:0]  rs1_data, rs2_data;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we;
  logic [7:0]  rd_wdata;
  logic [2:0]  status;
  logic        illegal_op;

  cpu_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_wdata   (rd_wdata),
    .status     (status),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rs1a, rs2a, rda;
    logic       we;
    logic       chk_wd;
    logic [7:0] wd;
    logic [2:0] st;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: memory kept as a flat byte array.
  int unsigned mb[2*MW];
  logic [2:0]  m_status = 3'b000;
  logic        m_ill    = 1'b0;

  function automatic int bidx(input int b);
    return ((b >> 1) % MW) * 2 + (b & 1);
  endfunction

  task automatic alu_model(input int op, input int a, input int b,
                           output int res, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = a + b;       c = s >> 8; res = s & 255; end
      1: begin s = a + 256 - b; c = s >> 8; res = s & 255; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (~a) & 255;
      6: res = a >> 1;
      default: res = a;
    endcase
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run(input logic rst, input logic [15:0] ins,
                     input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int op, res, c;
    rst_n    = rst;
    inst     = ins;
    rs1_data = a;
    rs2_data = b;
    op = int'(ins[15:12]);
    alu_model(op, int'(a), int'(b), res, c);
    e.rs1a   = ins[7:4];
    e.rs2a   = ins[3:0];
    e.rda    = ins[11:8];
    e.we     = rst && (op <= 7 || op >= 14);
    e.chk_wd = (op <= 7 || op >= 14);
    if (op == 15)      e.wd = ins[7:0];
    else if (op == 14) e.wd = 8'(mb[bidx(int'(a))]);
    else               e.wd = 8'(res);
    e.st  = m_status;
`ifdef EXEC_ILLEGAL_OP_EN
    e.ill = m_ill;
`else
    e.ill = 1'b0;
`endif
    q.push_back(e);
    // Advance reference state to what follows this rising edge.
    if (!rst) begin
      for (int i = 0; i < 2*MW; i++) mb[i] = 0;
      m_status = 3'b000;
      m_ill    = 1'b0;
    end else begin
      if (op <= 7) m_status = {c[0], (res == 0), res[7]};
      if (op == 13) mb[bidx(int'(a))] = int'(b);
      if (op >= 8 && op <= 12) m_ill = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; check at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs1_addr", 16'(rs1_addr), 16'(e.rs1a));
        chk("rs2_addr", 16'(rs2_addr), 16'(e.rs2a));
        chk("rd_addr",  16'(rd_addr),  16'(e.rda));
        chk("rd_we",    16'(rd_we),    16'(e.we));
        if (e.chk_wd) chk("rd_wdata", 16'(rd_wdata), 16'(e.wd));
        chk("status",   16'(status),   16'(e.st));
        chk("illegal_op", 16'(illegal_op), 16'(e.ill));
      end
    end
  end

  initial begin
    int op, wait_cnt;
    logic [15:0] ins;
    logic [7:0]  a;
    for (int i = 0; i < 2*MW; i++) mb[i] = 0;
    rst_n = 1'b0; inst = 16'h0000; rs1_data = 8'h00; rs2_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Directed sequence
    run(1'b1, 16'hF10A, 8'd0,  8'd0);
    run(1'b1, 16'h0112, 8'd10, 8'd2);
    run(1'b1, 16'h1112, 8'd12, 8'd3);
    run(1'b1, 16'h1112, 8'd3,  8'd12);
    run(1'b1, 16'hD012, 8'd4,  8'd10);
    run(1'b1, 16'hE310, 8'd4,  8'd0);
    run(1'b1, 16'hD012, 8'd5,  8'h5A);
    run(1'b1, 16'hE310, 8'd5,  8'd0);
    run(1'b1, 16'hE310, 8'd4,  8'd0);
    run(1'b0, 16'hD012, 8'd4,  8'hFF);
    run(1'b1, 16'hE310, 8'd4,  8'd0);
    run(1'b1, 16'hE310, 8'd5,  8'd0);
    run(1'b1, 16'h1112, 8'd3,  8'd12);
    run(1'b1, 16'h9123, 8'd1,  8'd2);
    run(1'b1, 16'hF2FF, 8'd0,  8'd0);

    // Randomized instruction stream
    for (int n = 0; n < 800; n++) begin
      op  = int'($urandom_range(0, 15));
      ins = {4'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15))};
      if ((op == 13 || op == 14) && $urandom_range(0, 1) == 1)
        a = 8'($urandom_range(0, 15));
      else
        a = 8'($urandom_range(0, 255));
      run(($urandom_range(0, 49) != 0), ins, a, 8'($urandom_range(0, 255)));
    end
    run(1'b1, 16'h8000, 8'd0, 8'd0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
